// File: rtl/led_trace_capture.sv
// Trace buffer for a narrow status bus: decimated sampling, masked-value trigger
// with programmable pre-trigger depth, and time-ordered readback by index.
module led_trace_capture #(
  parameter int NB_DATA  = 4,
  parameter int NB_ADDR  = 8,
  parameter int NB_DECIM = 16
) (
  input  logic                clock,
  input  logic                ck_rst,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic                i_arm,
  input  logic [NB_DATA-1:0]  i_trig_mask,
  input  logic [NB_DATA-1:0]  i_trig_value,
  input  logic [NB_ADDR-1:0]  i_pretrig,
  input  logic [NB_DECIM-1:0] i_decim,
  input  logic [NB_ADDR-1:0]  i_rd_addr,
  output logic [NB_DATA-1:0]  o_rd_data,
  output logic [2:0]          o_state,
  output logic                o_done
);

  localparam int DEPTH = 2 ** NB_ADDR;
  localparam logic [NB_ADDR-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state;
  logic [NB_ADDR-1:0]   wr_ptr;
  logic [NB_ADDR-1:0]   pre_cnt;
  logic [NB_ADDR-1:0]   post_cnt;
  logic [NB_ADDR-1:0]   start_ptr;
  logic [NB_ADDR-1:0]   p_lat;
  logic [NB_DECIM-1:0]  decim_cnt;
  logic [NB_DECIM-1:0]  d_lat;
  logic [NB_DATA-1:0]   mask_lat;
  logic [NB_DATA-1:0]   value_lat;
  logic                 done;
  logic [NB_DATA-1:0]   rd_data;
  logic [NB_DATA-1:0]   mem [DEPTH];

  logic                 capturing;
  logic                 strobe;
  logic                 hit;
  logic [NB_ADDR-1:0]   rd_idx;

  assign capturing = (state == PRE) || (state == ARMED) || (state == POST);
  assign strobe    = capturing && (decim_cnt == '0);
  assign hit       = ((i_data ^ value_lat) & mask_lat) == '0;
  assign rd_idx    = start_ptr + i_rd_addr;

  // Handshake: i_arm is a one-cycle request with no ready; it is taken only in
  // IDLE or DONE and silently dropped while a capture is in flight.
  always_ff @(posedge clock) begin
    if (ck_rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      start_ptr <= '0;
      p_lat     <= '0;
      d_lat     <= '0;
      decim_cnt <= '0;
      mask_lat  <= '0;
      value_lat <= '0;
      done      <= 1'b0;
    end else begin
      if (capturing) begin
        decim_cnt <= (decim_cnt == d_lat) ? '0 : decim_cnt + 1'b1;
      end
      case (state)
        IDLE, DONE: begin
          if (i_arm) begin
            p_lat     <= i_pretrig;
            d_lat     <= i_decim;
            mask_lat  <= i_trig_mask;
            value_lat <= i_trig_value;
            wr_ptr    <= '0;
            pre_cnt   <= '0;
            decim_cnt <= '0;
            done      <= 1'b0;
            state     <= (i_pretrig != '0) ? PRE : ARMED;
          end
        end
        PRE: begin
          if (strobe) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (pre_cnt == p_lat - 1'b1) begin
              state <= ARMED;
            end else begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end
        end
        ARMED: begin
          if (strobe) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (hit) begin
              // Oldest kept sample sits P slots behind the trigger sample.
              start_ptr <= wr_ptr - p_lat;
              post_cnt  <= LAST_IDX - p_lat;
              if (p_lat == LAST_IDX) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= POST;
              end
            end
          end
        end
        POST: begin
          if (strobe) begin
            wr_ptr   <= wr_ptr + 1'b1;
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == 1) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!ck_rst && strobe) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clock) begin
    if (ck_rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_idx];
    end
  end

  assign o_rd_data = rd_data;
  assign o_state   = state;
  assign o_done    = done;

endmodule
